// File: rtl/wb_crc_if.sv
// Wishbone B4 pipelined bus bundle shared by the interconnect, its masters and its slaves.
interface wb_if;
    logic [31:0] adr;
    logic [31:0] dat_m;
    logic [31:0] dat_s;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic        stall;
    logic        err;

    modport master (output adr, dat_m, sel, we, cyc, stb, input dat_s, ack, stall, err);
    modport slave  (input adr, dat_m, sel, we, cyc, stb, output dat_s, ack, stall, err);
endinterface

// File: rtl/wb_crc.sv
// Wishbone slave computing a parametrised CRC over written bytes; ack one cycle after acceptance.
// DATA writes stall the bus one cycle per enabled byte; reads and control writes never stall.
module wb_crc #(
    parameter int          WIDTH  = 32,
    parameter logic [31:0] POLY   = 32'h04C11DB7,
    parameter logic [31:0] INIT   = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT = 32'hFFFFFFFF,
    parameter bit          REFIN  = 1'b1,
    parameter bit          REFOUT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    wb_if.slave  wb
);
    localparam logic [1:0] A_CTRL = 2'd0;
    localparam logic [1:0] A_DATA = 2'd1;
    localparam logic [1:0] A_INIT = 2'd2;
    localparam logic [1:0] A_RAW  = 2'd3;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t           r_state, w_state_nxt;
    logic             w_busy, w_acc, w_wr, w_data_wr;
    logic [2:0]       w_nbytes;
    logic [1:0]       r_cnt;
    logic [31:0]      r_dat;
    logic [3:0]       r_sel;
    logic [1:0]       w_lane;
    logic [7:0]       w_byte;
    logic [WIDTH-1:0] r_crc, r_init, w_result;
    logic             r_ack;
    logic [31:0]      r_dat_s, w_rd_dat;
    logic             w_unused;

    function automatic logic [WIDTH-1:0] f_rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
        return r;
    endfunction

    // One input byte: optional bit reversal, align to the top, eight MSB-first division steps.
    function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] crc, input logic [7:0] b);
        logic [WIDTH-1:0] c;
        logic [7:0]       bb;
        for (int i = 0; i < 8; i++) bb[i] = REFIN ? b[7-i] : b[i];
        c = crc ^ (WIDTH'(bb) << (WIDTH - 8));
        for (int i = 0; i < 8; i++) c = c[WIDTH-1] ? ((c << 1) ^ POLY[WIDTH-1:0]) : (c << 1);
        return c;
    endfunction

    assign w_acc     = wb.cyc & wb.stb & ~w_busy;
    assign w_wr      = w_acc & wb.we;
    assign w_nbytes  = 3'($countones(wb.sel));
    assign w_data_wr = w_wr & (wb.adr[3:2] == A_DATA) & (w_nbytes != 3'd0);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_data_wr)     w_state_nxt = S_BUSY;
            S_BUSY:  if (r_cnt == 2'd0) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == S_BUSY);
    end

    // Lowest still-pending lane is the next byte in stream order.
    always_comb begin
        w_lane = 2'd0;
        for (int i = 3; i >= 0; i--) if (r_sel[i]) w_lane = 2'(i);
        w_byte = r_dat[{w_lane, 3'b000} +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 2'd0;
            r_dat <= 32'd0;
            r_sel <= 4'd0;
        end else if (w_data_wr) begin
            r_cnt <= 2'(w_nbytes - 3'd1);
            r_dat <= wb.dat_m;
            r_sel <= wb.sel;
        end else if (w_busy) begin
            r_cnt         <= r_cnt - 2'd1;
            r_sel[w_lane] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc  <= INIT[WIDTH-1:0];
            r_init <= INIT[WIDTH-1:0];
        end else begin
            if (w_busy)
                r_crc <= f_step(r_crc, w_byte);
            else if (w_wr && wb.adr[3:2] == A_CTRL && wb.dat_m[0])
                r_crc <= r_init;
            if (w_wr && wb.adr[3:2] == A_INIT)
                r_init <= wb.dat_m[WIDTH-1:0];
        end
    end

    assign w_result = (REFOUT ? f_rev(r_crc) : r_crc) ^ XOROUT[WIDTH-1:0];

    always_comb begin
        w_rd_dat = 32'd0;
        case (wb.adr[3:2])
            A_DATA:  w_rd_dat = 32'(w_result);
            A_INIT:  w_rd_dat = 32'(r_init);
            A_RAW:   w_rd_dat = 32'(r_crc);
            default: w_rd_dat = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack   <= 1'b0;
            r_dat_s <= 32'd0;
        end else begin
            r_ack   <= w_acc;
            r_dat_s <= (w_acc && !wb.we) ? w_rd_dat : 32'd0;
        end
    end

    assign wb.ack   = r_ack;
    assign wb.dat_s = r_dat_s;
    assign wb.stall = w_busy;
    assign wb.err   = 1'b0;

    assign w_unused = ^{wb.adr[31:4], wb.adr[1:0]};
endmodule

// File: tb/tb_wb_crc.sv
// Bench for wb_crc: three parameterisations on one clock, directed and random traffic vs a bit-serial CRC model.
module tb_wb_crc;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_adr, m_dat;
    logic [3:0]  m_sel;
    logic        m_we, m_cyc, m_stb;
    int          tgt;
    logic        s_ack, s_stall, s_err;
    logic [31:0] s_dat;
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    wb_if wb_a();
    wb_if wb_b();
    wb_if wb_c();

    assign wb_a.adr = m_adr;  assign wb_a.dat_m = m_dat;  assign wb_a.sel = m_sel;  assign wb_a.we = m_we;
    assign wb_a.cyc = m_cyc & (tgt == 0);  assign wb_a.stb = m_stb & (tgt == 0);
    assign wb_b.adr = m_adr;  assign wb_b.dat_m = m_dat;  assign wb_b.sel = m_sel;  assign wb_b.we = m_we;
    assign wb_b.cyc = m_cyc & (tgt == 1);  assign wb_b.stb = m_stb & (tgt == 1);
    assign wb_c.adr = m_adr;  assign wb_c.dat_m = m_dat;  assign wb_c.sel = m_sel;  assign wb_c.we = m_we;
    assign wb_c.cyc = m_cyc & (tgt == 2);  assign wb_c.stb = m_stb & (tgt == 2);

    assign s_ack   = (tgt == 0) ? wb_a.ack   : (tgt == 1) ? wb_b.ack   : wb_c.ack;
    assign s_stall = (tgt == 0) ? wb_a.stall : (tgt == 1) ? wb_b.stall : wb_c.stall;
    assign s_err   = (tgt == 0) ? wb_a.err   : (tgt == 1) ? wb_b.err   : wb_c.err;
    assign s_dat   = (tgt == 0) ? wb_a.dat_s : (tgt == 1) ? wb_b.dat_s : wb_c.dat_s;

    wb_crc u_crc32 (.clk(clk), .rst(rst), .wb(wb_a));
    wb_crc #(.WIDTH(16), .POLY(32'h1021), .INIT(32'hFFFF), .XOROUT(32'h0), .REFIN(1'b0), .REFOUT(1'b0))
        u_crc16 (.clk(clk), .rst(rst), .wb(wb_b));
    wb_crc #(.WIDTH(8), .POLY(32'h07), .INIT(32'h0), .XOROUT(32'h0), .REFIN(1'b0), .REFOUT(1'b0))
        u_crc8 (.clk(clk), .rst(rst), .wb(wb_c));

    // Reference parameters per target, and the model's view of each CRC state and INIT register.
    int          mw[3]    = '{32, 16, 8};
    logic [31:0] mpoly[3] = '{32'h04C11DB7, 32'h00001021, 32'h00000007};
    logic [31:0] minit[3] = '{32'hFFFFFFFF, 32'h0000FFFF, 32'h00000000};
    logic [31:0] mxor[3]  = '{32'hFFFFFFFF, 32'h00000000, 32'h00000000};
    bit          mref[3]  = '{1'b1, 1'b0, 1'b0};
    logic [31:0] m_crc[3];
    logic [31:0] m_init[3];

    localparam logic [1:0] R_CTRL = 2'd0, R_DATA = 2'd1, R_INIT = 2'd2, R_RAW = 2'd3;

    function automatic logic [31:0] msk(input int w);
        return (w == 32) ? 32'hFFFFFFFF : ((32'h1 << w) - 32'h1);
    endfunction

    // Bit-serial LFSR: each message bit enters at the top as feedback.
    function automatic logic [31:0] feed(input int t, input logic [31:0] crc_in, input logic [7:0] b);
        logic [31:0] crc;
        crc = crc_in;
        for (int i = 0; i < 8; i++) begin
            logic mb, fb;
            mb  = mref[t] ? b[i] : b[7-i];
            fb  = crc[mw[t]-1] ^ mb;
            crc = (crc << 1) & msk(mw[t]);
            if (fb) crc = crc ^ (mpoly[t] & msk(mw[t]));
        end
        return crc;
    endfunction

    function automatic logic [31:0] result(input int t);
        logic [31:0] r;
        r = 32'd0;
        if (mref[t]) for (int i = 0; i < mw[t]; i++) r[mw[t]-1-i] = m_crc[t][i];
        else r = m_crc[t];
        return r ^ (mxor[t] & msk(mw[t]));
    endfunction

    task automatic model_word(input int t, input logic [31:0] d, input logic [3:0] s);
        for (int l = 0; l < 4; l++) if (s[l]) m_crc[t] = feed(t, m_crc[t], d[8*l +: 8]);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait out any stall, return the data seen in the ack cycle.
    task automatic req(input int t, input logic we, input logic [1:0] ra, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd);
        logic [31:0] hi;
        int          w;
        hi = $urandom();
        tgt = t; m_we = we; m_adr = {hi[31:4], ra, 2'b00}; m_dat = d; m_sel = s;
        m_cyc = 1'b1; m_stb = 1'b1;
        #1;
        w = 0;
        while (s_stall && w < 20) begin @(posedge clk); #1; w++; end
        chk("stall_bound", 32'(w < 20), 32'd1);
        @(posedge clk); #1;
        m_cyc = 1'b0; m_stb = 1'b0;
        chk("ack", 32'(s_ack), 32'd1);
        rd = s_dat;
        if (we) chk("wr_dat_s_zero", rd, 32'd0);
    endtask

    task automatic wr_data(input int t, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] rd;
        req(t, 1'b1, R_DATA, d, s, rd);
        model_word(t, d, s);
    endtask

    task automatic wr_ctrl(input int t, input logic [31:0] d);
        logic [31:0] rd;
        req(t, 1'b1, R_CTRL, d, 4'hF, rd);
        if (d[0]) m_crc[t] = m_init[t];
    endtask

    task automatic wr_init(input int t, input logic [31:0] d);
        logic [31:0] rd;
        req(t, 1'b1, R_INIT, d, 4'hF, rd);
        m_init[t] = d & msk(mw[t]);
    endtask

    task automatic rd_reg(input int t, input logic [1:0] ra, output logic [31:0] rd);
        req(t, 1'b0, ra, $urandom(), 4'hF, rd);
    endtask

    // Number of consecutive stalled cycles from now on.
    task automatic stall_len(output int n);
        n = 0;
        while (s_stall && n < 10) begin n++; @(posedge clk); #1; end
    endtask

    task automatic stream_123456789(input int t);
        int n;
        wr_data(t, 32'h34333231, 4'hF); stall_len(n); chk("stall_w0", 32'(n), 32'd4);
        wr_data(t, 32'h38373635, 4'hF); stall_len(n); chk("stall_w1", 32'(n), 32'd4);
        wr_data(t, 32'h00000039, 4'h1); stall_len(n); chk("stall_w2", 32'(n), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, rd_p, v;
        logic [3:0]  s;
        int          n, acc_d, n_ack;

        rst = 1'b1; m_adr = '0; m_dat = '0; m_sel = '0; m_we = 1'b0; m_cyc = 1'b0; m_stb = 1'b0; tgt = 0;
        for (int t = 0; t < 3; t++) begin m_crc[t] = minit[t]; m_init[t] = minit[t]; end
        repeat (3) @(posedge clk);
        #1;
        for (int t = 0; t < 3; t++) begin
            tgt = t; #1;
            chk("rst_ack", 32'(s_ack), 32'd0);
            chk("rst_stall", 32'(s_stall), 32'd0);
            chk("rst_dat_s", s_dat, 32'd0);
            chk("rst_err", 32'(s_err), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        for (int t = 0; t < 3; t++) begin
            rd_reg(t, R_RAW, rd);  chk("rst_raw", rd, m_crc[t]);
            rd_reg(t, R_INIT, rd); chk("rst_init", rd, m_init[t]);
            rd_reg(t, R_CTRL, rd); chk("ctrl_read", rd, 32'd0);
        end

        // CRC-32/ISO-HDLC check value
        wr_ctrl(0, 32'd1);
        stream_123456789(0);
        rd_reg(0, R_DATA, rd);
        chk("crc32_check", rd, 32'hCBF43926);
        chk("crc32_model", rd, result(0));

        // CRC-16/CCITT-FALSE check value
        wr_ctrl(1, 32'd1);
        stream_123456789(1);
        rd_reg(1, R_DATA, rd);
        chk("crc16_check", rd, 32'h000029B1);

        // CRC-8 with sparse byte enables
        wr_ctrl(2, 32'd1);
        wr_data(2, 32'hAA32BB31, 4'b0101); stall_len(n); chk("crc8_stall", 32'(n), 32'd2);
        wr_data(2, 32'h34CC33DD, 4'b1010); stall_len(n); chk("crc8_stall", 32'(n), 32'd2);
        wr_data(2, 32'hEE36FF35, 4'b0101); stall_len(n); chk("crc8_stall", 32'(n), 32'd2);
        wr_data(2, 32'h38113722, 4'b1010); stall_len(n); chk("crc8_stall", 32'(n), 32'd2);
        wr_data(2, 32'h00390000, 4'b0100); stall_len(n); chk("crc8_stall", 32'(n), 32'd1);
        rd_reg(2, R_DATA, rd);
        chk("crc8_check", rd, 32'h000000F4);

        // sel=0 write is acked but neither stalls nor changes state
        wr_data(0, $urandom(), 4'h0); stall_len(n); chk("sel0_stall", 32'(n), 32'd0);
        rd_reg(0, R_RAW, rd); chk("sel0_raw", rd, m_crc[0]);

        // DATA write followed immediately by a RAW read held on stb
        v = $urandom();
        tgt = 0; m_we = 1'b1; m_adr = {28'h0, R_DATA, 2'b00}; m_dat = v; m_sel = 4'hF;
        m_cyc = 1'b1; m_stb = 1'b1;
        @(posedge clk); #1;
        model_word(0, v, 4'hF);
        m_we = 1'b0; m_adr = {28'h0, R_RAW, 2'b00};
        acc_d = 0; n_ack = 0; rd_p = 32'd0;
        for (int i = 0; i < 10; i++) begin
            if (s_ack) begin n_ack++; rd_p = s_dat; end
            if (acc_d == 0 && !s_stall) acc_d = i + 1;
            @(posedge clk); #1;
            if (acc_d != 0 && i + 1 == acc_d) begin m_cyc = 1'b0; m_stb = 1'b0; end
        end
        chk("pipe_accept_delay", 32'(acc_d), 32'd5);
        chk("pipe_ack_count", 32'(n_ack), 32'd2);
        chk("pipe_raw", rd_p, m_crc[0]);

        // INIT register and CTRL behaviour
        wr_init(0, 32'h12345678);
        rd_reg(0, R_INIT, rd); chk("init_read", rd, 32'h12345678);
        wr_ctrl(0, 32'd1);
        rd_reg(0, R_RAW, rd);  chk("init_raw", rd, 32'h12345678);
        wr_data(0, 32'hDEADBEEF, 4'b0110); stall_len(n);
        wr_ctrl(0, 32'hFFFFFFFE);
        rd_reg(0, R_RAW, rd);  chk("ctrl_bit0_clear", rd, m_crc[0]);

        // Random traffic against the model on every parameterisation
        for (int t = 0; t < 3; t++) begin
            wr_init(t, $urandom());
            wr_ctrl(t, 32'd1);
            for (int k = 0; k < 25; k++) begin
                s = 4'($urandom_range(0, 15));
                wr_data(t, $urandom(), s);
                stall_len(n);
                chk("rand_stall", 32'(n), 32'($countones(s)));
                if ($urandom_range(0, 3) == 0) begin
                    rd_reg(t, R_RAW, rd); chk("rand_raw", rd, m_crc[t]);
                end
            end
            rd_reg(t, R_DATA, rd); chk("rand_result", rd, result(t));
            rd_reg(t, R_INIT, rd); chk("rand_init", rd, m_init[t]);
        end

        // Reset two cycles into a 4-byte DATA write
        tgt = 0; m_we = 1'b1; m_adr = {28'h0, R_DATA, 2'b00}; m_dat = 32'h11223344; m_sel = 4'hF;
        m_cyc = 1'b1; m_stb = 1'b1;
        @(posedge clk); #1;
        m_cyc = 1'b0; m_stb = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int t = 0; t < 3; t++) begin m_crc[t] = minit[t]; m_init[t] = minit[t]; end
        chk("midrst_stall", 32'(s_stall), 32'd0);
        chk("midrst_ack", 32'(s_ack), 32'd0);
        rd_reg(0, R_RAW, rd);  chk("midrst_raw", rd, 32'hFFFFFFFF);
        rd_reg(0, R_INIT, rd); chk("midrst_init", rd, 32'hFFFFFFFF);
        stream_123456789(0);
        rd_reg(0, R_DATA, rd);
        chk("midrst_crc32", rd, 32'hCBF43926);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_crc.md
# wb_crc

Wishbone B4 pipelined slave that computes a parametrised CRC (width, polynomial, init, final XOR, input/output reflection) over bytes written by the CPU. It sits on the shared-bus interconnect beside `wb_spramx32` as a hardware successor to the software CRC-32 test. It generalises that fixed CRC-32 to any CRC of width 8–32. Bytes are consumed one per clock, so the slave stalls the bus while a data word is being absorbed.

## Interface
- `WIDTH`, 32: CRC width in bits, legal range 8–32.
- `POLY`, 32'h04C11DB7: generator polynomial, implicit top bit omitted; low `WIDTH` bits used.
- `INIT`, 32'hFFFFFFFF: reset value of the INIT register and of the CRC state.
- `XOROUT`, 32'hFFFFFFFF: value XORed into the result on read.
- `REFIN`, 1: when 1, each input byte is processed LSB-first.
- `REFOUT`, 1: when 1, the CRC state is bit-reversed over `WIDTH` before `XOROUT` is applied.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `wb` `wb_if.slave` —: the slave port. It uses `adr[3:2]`, `dat_m[31:0]`, `sel[3:0]`, `we`, `cyc` and `stb` as inputs. It drives `dat_s[31:0]`, `ack`, `stall` and `err`; `err` is tied to 0.

## Operation
- Register map by `adr[3:2]`. Higher address bits are ignored, because the interconnect decodes them.
  - 0 CTRL: a write with `dat_m[0]=1` loads the CRC state from INIT. Reads return 0.
  - 1 DATA: a write queues the bytes enabled by `sel`, processed from byte lane 0 to byte lane 3 with disabled lanes skipped. A read returns the result, zero-extended to 32 bits.
  - 2 INIT: read/write, low `WIDTH` bits; upper bits read as 0.
  - 3 RAW: read-only raw CRC state, with no reflection and no XOR. Writes are ignored.
- Request acceptance: a request is accepted when `cyc & stb & ~stall`.
- Byte step: for each byte `b` (bit-reversed first when `REFIN=1`), align `b` to the top of the state and do 8 MSB-first shift/XOR steps with `POLY`, all modulo `WIDTH` bits.
- Result: `(REFOUT ? rev_WIDTH(state) : state) ^ XOROUT[WIDTH-1:0]`.
- Engine: two states, IDLE and BUSY. A DATA write with N = popcount(`sel`) > 0 goes to BUSY with a 2-bit remaining-byte count and a latched copy of data and `sel`. One byte is processed per clock. The engine returns to IDLE after the Nth byte. A DATA write with `sel=0` does not enter BUSY.
- `stall` equals BUSY (registered). No request of any kind is accepted while BUSY, so reads always see the completed state.
- `cyc` deasserting while BUSY does not abort processing.
- Reset, including mid-operation: state, INIT and pending bytes are restored or dropped as follows.
  - CRC state := `INIT`; INIT register := `INIT`.
  - BUSY cleared and pending bytes discarded.
  - `ack`=0, `stall`=0, `dat_s`=0.

## Timing
- `ack` is registered and high for exactly one cycle, the cycle after acceptance, for every accepted request, including unmapped lanes and `sel=0` writes.
- `dat_s` is valid in the `ack` cycle and holds 0 otherwise.
- A DATA write accepted at edge k asserts `stall` for cycles k+1 … k+N. Bytes are absorbed at edges k+1 … k+N, and the next request can be accepted at edge k+N+1 at the earliest.
- Back-to-back 4-byte writes therefore sustain 1 word per 5 cycles.
- A CTRL init or INIT write takes effect at its acceptance edge. A read accepted on the next cycle sees the new value.
- Reads, CTRL writes and INIT writes never stall, so full pipelining gives 1 request per cycle.

## Test plan
- CRC-32/ISO-HDLC check value, default parameters:
  - Stimulus: CTRL=1, then DATA writes 32'h34333231 `sel`=F, 32'h38373635 `sel`=F, 32'h00000039 `sel`=1.
  - Required: DATA read = 32'hCBF43926.
  - Required: `stall` is high for exactly 4, 4 and 1 cycles respectively.
- CRC-16/CCITT-FALSE:
  - Parameters: `WIDTH`=16, `POLY`=16'h1021, `INIT`=16'hFFFF, `REFIN`=`REFOUT`=0, `XOROUT`=0.
  - Stimulus: the same "123456789" stream.
  - Required: DATA read = 32'h000029B1.
- CRC-8 with sparse byte enables:
  - Parameters: `WIDTH`=8, `POLY`=8'h07, `INIT`=0, no reflection, `XOROUT`=0.
  - Stimulus: "123456789" written with `sel`=4'b0101 and 4'b1010 lane mixes, lanes carrying the correct bytes in order.
  - Required: DATA read = 32'h000000F4.
- Pipelining and stall:
  - Stimulus: a DATA write `sel`=F followed immediately by a RAW read held on `stb`.
  - Required: the read is accepted exactly 5 cycles after the write.
  - Required: each request gets exactly one `ack`.
  - Required: the read returns the state after all 4 bytes.
- INIT register:
  - Stimulus: write INIT=32'h12345678, read INIT, write CTRL=1, read RAW.
  - Required: both reads return 32'h12345678 (with `WIDTH`=32).
  - Required: a CTRL write with bit0=0 leaves RAW unchanged.
- Reset mid-operation:
  - Stimulus: assert `rst` for one cycle 2 cycles into a 4-byte DATA write.
  - Required: `stall`=0 and `ack`=0 on the next cycle.
  - Required: RAW and INIT read back as 32'hFFFFFFFF.
  - Required: a fresh "123456789" stream yields 32'hCBF43926.
